pcie_tl_tx_arb: RTL and testbench
=================================

PCIE_TL_TX_ARB -- requirements
Module: pcie_tl_tx_arb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 224, TLP entry width per queue.
REQ-002 SHALL have parameter CRED_W, default 8, header-credit counter width.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en_i  input  1  grant enable; low blocks new grants.
REQ-006 SHALL have port q_empty_i  input  3  per-queue empty; index 0=P, 1=NP, 2=CPL.
REQ-007 SHALL have port q_rden_o  output  3  per-queue pop strobe, one-hot or zero.
REQ-008 SHALL have port q_rdata_i  input  3xDATA_WIDTH  per-queue head entry, valid when not empty.
REQ-009 SHALL have port fc_init_i  input  1  one-cycle pulse loading initial credits.
REQ-010 SHALL have port fc_init_hdr_i  input  3xCRED_W  initial header credits per class; 0 means infinite.
REQ-011 SHALL have port fc_upd_i  input  3  per-class one-credit return pulse.
REQ-012 SHALL have port tlp_valid_o  output  1  output TLP valid.
REQ-013 SHALL have port tlp_data_o  output  DATA_WIDTH  output TLP entry.
REQ-014 SHALL have port tlp_class_o  output  2  class of tlp_data_o (0/1/2).
REQ-015 SHALL have port tlp_ready_i  input  1  downstream accept; transfer = valid & ready.
REQ-016 SHALL have port fc_ready_o  output  1  high once credits initialized.

Function
REQ-017 SHALL implement FSM FC_WAIT -> RUN; fc_init_i in FC_WAIT loads counters, infinite flags (init==0) and enters RUN next cycle; RUN is left only by reset.
REQ-018 SHALL ignore fc_init_i in RUN and fc_upd_i in FC_WAIT; SHALL grant nothing in FC_WAIT.
REQ-019 SHALL deem queue q eligible when !q_empty_i[q] and (infinite[q] or credit[q] != 0).
REQ-020 SHALL grant only when RUN, en_i high and output slot free (!tlp_valid_o or tlp_ready_i).
REQ-021 SHALL select among eligible queues round-robin, starting at index after last granted; last-granted resets to 2 (so P first).
REQ-022 SHALL on grant assert q_rden_o[q] combinationally that cycle, register q_rdata_i[q] and q into tlp_data_o/tlp_class_o, and set tlp_valid_o next cycle (1-cycle latency).
REQ-023 SHALL sustain one TLP per cycle when tlp_ready_i held high and queues eligible.
REQ-024 SHALL clear tlp_valid_o after transfer with no new grant; SHALL hold tlp_data_o/tlp_class_o stable while valid & !ready.
REQ-025 SHALL decrement credit[q] on grant of finite q, increment on fc_upd_i[q]; both same cycle leaves it unchanged.
REQ-026 SHALL saturate credit at 2^CRED_W-1 on increment; SHALL never grant at credit 0 (no underflow).
REQ-027 SHALL keep infinite classes unchanged by grants and fc_upd_i.
REQ-028 SHALL, with en_i low, complete a pending output transfer normally.

Reset
REQ-029 SHALL on rst_n low: state FC_WAIT, credits 0, infinite flags 0, last-granted 2, tlp_valid_o 0, tlp_data_o 0, tlp_class_o 0, fc_ready_o 0; q_rden_o 0 during reset.
REQ-030 SHALL discard any held output TLP on reset mid-operation.

Configuration
REQ-031 SHALL, with PCIE_TL_ARB_CPL_PRIO_EN defined, grant eligible CPL with strict priority over P/NP, RR between P/NP; without it, plain 3-way RR per REQ-021.

Structure
REQ-032 SHALL place class enum (P/NP/CPL), NUM_CLASS=3 and FSM state typedef in package pcie_tl_pkg.
REQ-033 SHALL instantiate one sub-module pcie_tl_rr_arb (3-requester round-robin, last-grant pointer).

Verification
REQ-034 SHALL test init {P=2,NP=1,CPL=0}, all queues full, ready=1 -> grant order P,NP,CPL,P,CPL,CPL...; P stops after 2, NP after 1.
REQ-035 SHALL test P credit 0 with fc_upd_i[0] pulse -> exactly one P TLP granted next cycle.
REQ-036 SHALL test tlp_ready_i low 5 cycles with valid -> data/class stable, q_rden_o 0 throughout.
REQ-037 SHALL test credit 255 plus fc_upd_i -> stays 255; grant and fc_upd_i same cycle at 5 -> stays 5.
REQ-038 SHALL test grants before fc_init_i -> none; rst_n low mid-stream -> tlp_valid_o 0, FC_WAIT next cycle.
REQ-039 SHALL test, with PCIE_TL_ARB_CPL_PRIO_EN, all queues eligible -> CPL granted every cycle until empty.

Source files
------------

// File: rtl/pcie_tl_pkg.sv
// Shared types for the PCIe transaction-layer transmit arbiter:
// traffic class encoding, class count and credit FSM states.
package pcie_tl_pkg;

  localparam int NUM_CLASS = 3;

  // Queue / class index: posted, non-posted, completion.
  typedef enum logic [1:0] {
    CLS_P   = 2'd0,
    CLS_NP  = 2'd1,
    CLS_CPL = 2'd2
  } tlp_class_e;

  // Credit FSM: waiting for initial credits, then running until reset.
  typedef enum logic {
    FC_WAIT = 1'b0,
    RUN     = 1'b1
  } fc_state_e;

endpackage

// File: rtl/pcie_tl_tx_arb_if.sv
// Queue-side and output-side handshake bundle of the TX arbiter.
// master = arbiter, slave = surrounding queues / downstream consumer.
interface pcie_tl_tx_arb_if #(
  parameter int DATA_WIDTH = 224
);
  import pcie_tl_pkg::*;

  logic [NUM_CLASS-1:0]            q_empty_i;
  logic [NUM_CLASS-1:0]            q_rden_o;
  logic [NUM_CLASS*DATA_WIDTH-1:0] q_rdata_i;
  logic                            tlp_valid_o;
  logic [DATA_WIDTH-1:0]           tlp_data_o;
  logic [1:0]                      tlp_class_o;
  logic                            tlp_ready_i;

  modport master (
    input  q_empty_i, q_rdata_i, tlp_ready_i,
    output q_rden_o, tlp_valid_o, tlp_data_o, tlp_class_o
  );

  modport slave (
    output q_empty_i, q_rdata_i, tlp_ready_i,
    input  q_rden_o, tlp_valid_o, tlp_data_o, tlp_class_o
  );

endinterface

// File: rtl/pcie_tl_rr_arb.sv
// Three-requester round-robin arbiter. The search starts one past the
// last winner; the pointer only moves when a grant is issued.
module pcie_tl_rr_arb
  import pcie_tl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_CLASS-1:0] req_i,
  output logic [NUM_CLASS-1:0] gnt_o
);

  logic [1:0] last_q;
  logic [1:0] last_d;
  logic [1:0] idx;
  logic       found;

  // Rotating first-hit search beginning after the previous winner.
  always_comb begin
    gnt_o  = '0;
    last_d = last_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NUM_CLASS; k++) begin
      idx = 2'((int'(last_q) + k) % NUM_CLASS);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        last_d     = idx;
        found      = 1'b1;
      end
    end
  end

  // Last-winner pointer; resets to CPL so that P is searched first.
  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 2'd2;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/pcie_tl_tx_arb.sv
// PCIe TL transmit arbiter: picks one of the P/NP/CPL queues per cycle
// subject to header flow-control credits, and presents the popped entry
// on a registered valid/ready output slot.
// Optional build macro PCIE_TL_ARB_CPL_PRIO_EN: completions win over P/NP
// whenever eligible; P and NP still alternate round-robin.
module pcie_tl_tx_arb
  import pcie_tl_pkg::*;
#(
  parameter int DATA_WIDTH = 224,
  parameter int CRED_W     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en_i,
  input  logic                        fc_init_i,
  input  logic [NUM_CLASS*CRED_W-1:0] fc_init_hdr_i,
  input  logic [NUM_CLASS-1:0]        fc_upd_i,
  output logic                        fc_ready_o,
  pcie_tl_tx_arb_if.master            bus
);

  fc_state_e             state_q, state_d;
  logic [CRED_W-1:0]     cred_q [NUM_CLASS];
  logic [CRED_W-1:0]     cred_d [NUM_CLASS];
  logic [NUM_CLASS-1:0]  inf_q, inf_d;
  logic [NUM_CLASS-1:0]  elig, req, gnt;
  logic                  can_grant;
  logic                  tlp_valid_q, tlp_valid_d;
  logic [DATA_WIDTH-1:0] tlp_data_q, tlp_data_d;
  logic [1:0]            tlp_class_q, tlp_class_d;

  // Decrement on grant, increment on credit return, saturate at all-ones.
  // A grant is only issued at non-zero credit, so no underflow guard.
  function automatic logic [CRED_W-1:0] cred_next(input logic [CRED_W-1:0] c,
                                                  input logic dec, input logic inc);
    if (dec && !inc) return c - 1'b1;
    if (inc && !dec && (c != {CRED_W{1'b1}})) return c + 1'b1;
    return c;
  endfunction

  // Eligibility and grant qualification feeding the round-robin core.
  always_comb begin
    elig = '0;
    for (int q = 0; q < NUM_CLASS; q++)
      elig[q] = !bus.q_empty_i[q] && (inf_q[q] || (cred_q[q] != '0));
    can_grant = rst_n && (state_q == RUN) && en_i && (!tlp_valid_q || bus.tlp_ready_i);
`ifdef PCIE_TL_ARB_CPL_PRIO_EN
    req = elig[2] ? 3'b100 : (elig & 3'b011);
`else
    req = elig;
`endif
    if (!can_grant) req = '0;
  end

  pcie_tl_rr_arb u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req),
    .gnt_o (gnt)
  );

  // Credit FSM: one-shot load in FC_WAIT, credit accounting in RUN.
  always_comb begin
    state_d = state_q;
    inf_d   = inf_q;
    for (int q = 0; q < NUM_CLASS; q++) cred_d[q] = cred_q[q];
    case (state_q)
      FC_WAIT: begin
        if (fc_init_i) begin
          state_d = RUN;
          for (int q = 0; q < NUM_CLASS; q++) begin
            cred_d[q] = fc_init_hdr_i[q*CRED_W +: CRED_W];
            inf_d[q]  = (fc_init_hdr_i[q*CRED_W +: CRED_W] == '0);
          end
        end
      end
      RUN: begin
        for (int q = 0; q < NUM_CLASS; q++)
          if (!inf_q[q]) cred_d[q] = cred_next(cred_q[q], gnt[q], fc_upd_i[q]);
      end
      default: ;
    endcase
  end

  // Output slot: load on grant, drop valid after a transfer with no refill.
  always_comb begin
    tlp_valid_d = tlp_valid_q;
    tlp_data_d  = tlp_data_q;
    tlp_class_d = tlp_class_q;
    if (|gnt) begin
      tlp_valid_d = 1'b1;
      for (int q = 0; q < NUM_CLASS; q++) begin
        if (gnt[q]) begin
          tlp_data_d  = bus.q_rdata_i[q*DATA_WIDTH +: DATA_WIDTH];
          tlp_class_d = 2'(q);
        end
      end
    end else if (bus.tlp_ready_i) begin
      tlp_valid_d = 1'b0;
    end
  end

  // State, credit and output registers; reset discards any held TLP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FC_WAIT;
      inf_q       <= '0;
      for (int q = 0; q < NUM_CLASS; q++) cred_q[q] <= '0;
      tlp_valid_q <= 1'b0;
      tlp_data_q  <= '0;
      tlp_class_q <= '0;
    end else begin
      state_q     <= state_d;
      inf_q       <= inf_d;
      for (int q = 0; q < NUM_CLASS; q++) cred_q[q] <= cred_d[q];
      tlp_valid_q <= tlp_valid_d;
      tlp_data_q  <= tlp_data_d;
      tlp_class_q <= tlp_class_d;
    end
  end

  assign bus.q_rden_o    = gnt;
  assign bus.tlp_valid_o = tlp_valid_q;
  assign bus.tlp_data_o  = tlp_data_q;
  assign bus.tlp_class_o = tlp_class_q;
  assign fc_ready_o      = (state_q == RUN);

endmodule

// File: tb/tb_pcie_tl_tx_arb.sv
// Testbench for pcie_tl_tx_arb: queue models, a cycle-level reference
// model of the arbitration/credit rules, a vector table and directed
// multi-cycle sequences, then randomized traffic.
module tb_pcie_tl_tx_arb;
  import pcie_tl_pkg::*;

  localparam int DW   = 224;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  typedef logic [DW-1:0] data_t;
  typedef struct { int c0, c1, c2; int d0, d1, d2; int e0, e1, e2; } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, en_i, fc_init_i, fc_ready_o;
  logic [3*CW-1:0] fc_init_hdr_i;
  logic [2:0]    fc_upd_i;

  pcie_tl_tx_arb_if #(.DATA_WIDTH(DW)) bus();

  pcie_tl_tx_arb #(.DATA_WIDTH(DW), .CRED_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_i          (en_i),
    .fc_init_i     (fc_init_i),
    .fc_init_hdr_i (fc_init_hdr_i),
    .fc_upd_i      (fc_upd_i),
    .fc_ready_o    (fc_ready_o),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Queue contents presented to the DUT.
  data_t f0[$], f1[$], f2[$];

  // Reference model state.
  int    m_run, m_last, m_cls, m_g;
  int    m_cred[3];
  bit    m_inf[3];
  bit    m_vld;
  data_t m_data;

  int         n_chk, n_fail;
  int         gcount[3];
  int         glog[$];
  logic [2:0] obs_rden;
  vec_t       vt[5];

  function automatic int fsize(int q);
    case (q) 0: return f0.size(); 1: return f1.size(); default: return f2.size(); endcase
  endfunction

  function automatic data_t ffront(int q);
    case (q) 0: return f0[0]; 1: return f1[0]; default: return f2[0]; endcase
  endfunction

  function automatic data_t rnd_data();
    data_t d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic fpush(int q, data_t d);
    case (q) 0: f0.push_back(d); 1: f1.push_back(d); default: f2.push_back(d); endcase
  endtask

  task automatic fpop(int q);
    case (q) 0: void'(f0.pop_front()); 1: void'(f1.pop_front()); default: void'(f2.pop_front()); endcase
  endtask

  task automatic push_n(int q, int n);
    for (int i = 0; i < n; i++) fpush(q, rnd_data());
  endtask

  task automatic chk(input string nm, input data_t act, input data_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_q();
    for (int q = 0; q < 3; q++) begin
      bus.q_empty_i[q]           = (fsize(q) == 0);
      bus.q_rdata_i[q*DW +: DW]  = (fsize(q) != 0) ? ffront(q) : '0;
    end
  endtask

  // Which queue the rules say should be popped right now (-1: none).
  function automatic int pick();
    bit el[3];
    if (!rst_n || m_run == 0 || !en_i || (m_vld && !bus.tlp_ready_i)) return -1;
    for (int q = 0; q < 3; q++) el[q] = (fsize(q) > 0) && (m_inf[q] || m_cred[q] > 0);
`ifdef PCIE_TL_ARB_CPL_PRIO_EN
    if (el[2]) return 2;
`endif
    for (int k = 1; k <= 3; k++) begin
      int q;
      q = (m_last + k) % 3;
      if (el[q]) return q;
    end
    return -1;
  endfunction

  task automatic model_update();
    if (!rst_n) begin
      m_run = 0; m_last = 2; m_vld = 0; m_data = '0; m_cls = 0;
      for (int q = 0; q < 3; q++) begin m_cred[q] = 0; m_inf[q] = 0; end
      return;
    end
    if (m_run == 0) begin
      if (fc_init_i) begin
        m_run = 1;
        for (int q = 0; q < 3; q++) begin
          m_cred[q] = int'(fc_init_hdr_i[q*CW +: CW]);
          m_inf[q]  = (m_cred[q] == 0);
        end
      end
    end else begin
      for (int q = 0; q < 3; q++) begin
        if (!m_inf[q]) begin
          m_cred[q] = m_cred[q] - ((m_g == q) ? 1 : 0) + (fc_upd_i[q] ? 1 : 0);
          if (m_cred[q] > CMAX) m_cred[q] = CMAX;
        end
      end
    end
    if (m_g >= 0) begin
      m_vld = 1; m_data = ffront(m_g); m_cls = m_g; m_last = m_g;
      fpop(m_g);
    end else if (m_vld && bus.tlp_ready_i) begin
      m_vld = 0;
    end
  endtask

  // One clock: check at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    logic [2:0] exp_rden;
    drive_q();
    @(negedge clk);
    m_g      = pick();
    exp_rden = (m_g < 0) ? 3'b000 : 3'(1 << m_g);
    chk("q_rden_o",    data_t'(bus.q_rden_o),    data_t'(exp_rden));
    chk("tlp_valid_o", data_t'(bus.tlp_valid_o), data_t'(m_vld));
    chk("tlp_class_o", data_t'(bus.tlp_class_o), data_t'(m_cls));
    chk("tlp_data_o",  bus.tlp_data_o,           m_data);
    chk("fc_ready_o",  data_t'(fc_ready_o),      data_t'(m_run));
    obs_rden = bus.q_rden_o;
    for (int q = 0; q < 3; q++) if (obs_rden[q]) begin gcount[q]++; glog.push_back(q); end
    @(posedge clk);
    model_update();
    #1;
    fc_init_i = 1'b0;
    fc_upd_i  = '0;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic clr_counts();
    for (int q = 0; q < 3; q++) gcount[q] = 0;
    glog.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    f0.delete(); f1.delete(); f2.delete();
    cycle(); cycle();
    rst_n = 1'b1; en_i = 1'b1; bus.tlp_ready_i = 1'b1;
  endtask

  task automatic fc_load(int c0, int c1, int c2);
    fc_init_hdr_i[0*CW +: CW] = CW'(c0);
    fc_init_hdr_i[1*CW +: CW] = CW'(c1);
    fc_init_hdr_i[2*CW +: CW] = CW'(c2);
    fc_init_i = 1'b1;
    cycle();
  endtask

  initial begin
    int exp_ord[6];
    data_t p_first;
    int snap;

    vt[0] = '{2, 1, 0,   8, 8, 8,   2, 1, 8};
    vt[1] = '{0, 0, 0,   3, 4, 5,   3, 4, 5};
    vt[2] = '{5, 5, 5,   2, 10, 0,  2, 5, 0};
    vt[3] = '{255, 1, 1, 20, 0, 0,  20, 0, 0};
    vt[4] = '{1, 1, 1,   4, 4, 4,   1, 1, 1};
    exp_ord = '{0, 1, 2, 0, 2, 2};

    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; en_i = 1'b0; fc_init_i = 1'b0; fc_init_hdr_i = '0; fc_upd_i = '0;
    bus.tlp_ready_i = 1'b0;
    m_run = 0; m_last = 2; m_vld = 0; m_data = '0; m_cls = 0; m_g = -1;
    for (int q = 0; q < 3; q++) begin m_cred[q] = 0; m_inf[q] = 0; end
    drive_q();
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    do_reset();
    chk("reset_fc_ready", data_t'(fc_ready_o), '0);
    chk("reset_valid",    data_t'(bus.tlp_valid_o), '0);
    chk("reset_data",     bus.tlp_data_o, '0);

    // Vector table: per-class grant totals once all queues drain.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      push_n(0, vt[v].d0); push_n(1, vt[v].d1); push_n(2, vt[v].d2);
      clr_counts();
      fc_load(vt[v].c0, vt[v].c1, vt[v].c2);
      run(40);
      chk($sformatf("vec%0d_p", v),   data_t'(gcount[0]), data_t'(vt[v].e0));
      chk($sformatf("vec%0d_np", v),  data_t'(gcount[1]), data_t'(vt[v].e1));
      chk($sformatf("vec%0d_cpl", v), data_t'(gcount[2]), data_t'(vt[v].e2));
    end

`ifndef PCIE_TL_ARB_CPL_PRIO_EN
    // Grant order with credits P=2, NP=1, CPL infinite.
    do_reset();
    push_n(0, 8); push_n(1, 8); push_n(2, 8);
    fc_load(2, 1, 0);
    clr_counts();
    run(6);
    chk("order_len", data_t'(glog.size()), data_t'(6));
    for (int i = 0; i < 6; i++)
      chk($sformatf("order_%0d", i), data_t'((i < glog.size()) ? glog[i] : -1), data_t'(exp_ord[i]));
`else
    // Completion priority: CPL wins every cycle until its queue drains.
    do_reset();
    push_n(0, 4); push_n(1, 4); push_n(2, 4);
    fc_load(0, 0, 0);
    clr_counts();
    run(4);
    chk("prio_len", data_t'(glog.size()), data_t'(4));
    for (int i = 0; i < 4; i++)
      chk($sformatf("prio_%0d", i), data_t'((i < glog.size()) ? glog[i] : -1), data_t'(2));
`endif

    // Credit return at zero credit releases exactly one P TLP next cycle.
    do_reset();
    push_n(0, 3);
    fc_load(1, 1, 1);
    clr_counts();
    run(5);
    chk("cr0_first", data_t'(gcount[0]), data_t'(1));
    fc_upd_i = 3'b001;
    cycle();
    chk("cr0_upd_cycle", data_t'(obs_rden), data_t'(3'b000));
    cycle();
    chk("cr0_next_cycle", data_t'(obs_rden), data_t'(3'b001));
    run(4);
    chk("cr0_total", data_t'(gcount[0]), data_t'(2));

    // Backpressure: output held stable, no pops while not ready.
    do_reset();
    bus.tlp_ready_i = 1'b0;
    p_first = rnd_data();
    fpush(0, p_first); push_n(0, 4); push_n(1, 4);
    fc_load(0, 0, 0);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_rden",  data_t'(obs_rden), '0);
      chk("bp_valid", data_t'(bus.tlp_valid_o), data_t'(1));
      chk("bp_data",  bus.tlp_data_o, p_first);
      chk("bp_class", data_t'(bus.tlp_class_o), data_t'(0));
    end
    bus.tlp_ready_i = 1'b1;
    cycle();
    chk("bp_release", data_t'(obs_rden), data_t'(3'b010));

    // Saturation at 255 and simultaneous grant/return.
    do_reset();
    fc_load(255, 1, 1);
    fc_upd_i = 3'b001; cycle();
    fc_upd_i = 3'b001; cycle();
    push_n(0, 270);
    clr_counts();
    run(300);
    chk("sat_total", data_t'(gcount[0]), data_t'(255));
    do_reset();
    fc_load(5, 1, 1);
    clr_counts();
    push_n(0, 10);
    fc_upd_i = 3'b001;
    cycle();
    chk("same_cycle_grant", data_t'(obs_rden), data_t'(3'b001));
    run(15);
    chk("same_cycle_total", data_t'(gcount[0]), data_t'(6));

    // Nothing granted before credit init; reset mid-stream drops the TLP.
    do_reset();
    push_n(0, 8); push_n(1, 8); push_n(2, 8);
    clr_counts();
    run(5);
    chk("preinit_grants", data_t'(gcount[0] + gcount[1] + gcount[2]), '0);
    chk("preinit_ready",  data_t'(fc_ready_o), '0);
    fc_load(0, 0, 0);
    run(3);
    rst_n = 1'b0;
    cycle();
    chk("rst_rden",     data_t'(obs_rden), '0);
    chk("rst_valid",    data_t'(bus.tlp_valid_o), '0);
    chk("rst_fc_ready", data_t'(fc_ready_o), '0);
    chk("rst_data",     bus.tlp_data_o, '0);
    rst_n = 1'b1;
    snap = gcount[0] + gcount[1] + gcount[2];
    run(4);
    chk("post_rst_grants", data_t'(gcount[0] + gcount[1] + gcount[2]), data_t'(snap));
    chk("post_rst_ready",  data_t'(fc_ready_o), '0);

    // Randomized traffic against the reference model.
    for (int ep = 0; ep < 4; ep++) begin
      int c[3];
      do_reset();
      for (int i = 0; i < 10; i++) begin
        fc_upd_i = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) push_n($urandom_range(0, 2), 1);
        cycle();
      end
      for (int q = 0; q < 3; q++)
        c[q] = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      fc_load(c[0], c[1], c[2]);
      for (int i = 0; i < 250; i++) begin
        en_i            = ($urandom_range(0, 9) < 8);
        bus.tlp_ready_i = ($urandom_range(0, 9) < 7);
        fc_init_i       = ($urandom_range(0, 19) == 0);
        fc_init_hdr_i   = {CW'($urandom), CW'($urandom), CW'($urandom)};
        for (int q = 0; q < 3; q++) begin
          fc_upd_i[q] = ($urandom_range(0, 3) == 0);
          if ($urandom_range(0, 9) < 3 && fsize(q) < 8) push_n(q, 1);
        end
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
